// File: rtl/factorial_engine_if.sv
// Handshake bundle between a requester and the factorial engine.
//   go     : start request from the requester
//   n      : operand, sampled when go is accepted
//   busy   : engine is running a computation
//   done   : one-cycle completion strobe
//   err    : operand exceeded the largest representable factorial
//   result : n! of the last completed run (0 on error)
interface factorial_engine_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWIDTH = 4
);
    logic              go;
    logic [NWIDTH-1:0] n;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  result;

    modport master (
        output go,
        output n,
        input  busy,
        input  done,
        input  err,
        input  result
    );

    modport slave (
        input  go,
        input  n,
        output busy,
        output done,
        output err,
        output result
    );
endinterface

// File: rtl/factorial_engine.sv
// Iterative unsigned factorial unit. On an accepted go it captures n and
// computes n! by repeated multiply/decrement, then presents result together
// with a one-cycle done strobe so a downstream load-enable register captures
// each answer exactly once.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous, active-high reset
//   bus : slave side of factorial_engine_if (go/n in; busy/done/err/result out)
module factorial_engine #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWIDTH = 4,
    parameter int unsigned MAXN   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    factorial_engine_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MULT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NWIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]  prod, prod_nxt;
    logic [WIDTH-1:0]  result, result_nxt;
    logic              err, err_nxt;
    logic              busy, busy_nxt;
    logic              done, done_nxt;

    // Next-state and datapath decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        prod_nxt   = prod;
        result_nxt = result;
        err_nxt    = err;

        case (state)
            IDLE: begin
                if (bus.go) begin
                    cnt_nxt   = bus.n;
                    prod_nxt  = WIDTH'(1);
                    err_nxt   = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                // cnt still holds the untouched captured operand here.
                if (32'(cnt) > MAXN) begin
                    result_nxt = '0;
                    err_nxt    = 1'b1;
                    state_nxt  = FIN;
                end else begin
                    state_nxt  = MULT;
                end
            end
            MULT: begin
                if (cnt > NWIDTH'(1)) begin
                    // Low WIDTH bits only; cannot overflow for cnt <= MAXN.
                    prod_nxt = prod * WIDTH'(cnt);
                    cnt_nxt  = cnt - NWIDTH'(1);
                end else begin
                    result_nxt = prod;
                    state_nxt  = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status flags are registered decodes of the state being entered.
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            prod   <= prod_nxt;
            result <= result_nxt;
            err    <= err_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
    assign bus.result = result;

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: a vector table of single runs plus
// hand-written sequences for GO re-pulsing, GO held high and mid-run reset.
module tb_factorial_engine;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NWIDTH = 4;
    localparam int unsigned MAXN   = 12;
    localparam int          BUDGET = 40;

    logic clk;
    logic rst;

    factorial_engine_if #(.WIDTH(WIDTH), .NWIDTH(NWIDTH)) bus ();

    factorial_engine #(.WIDTH(WIDTH), .NWIDTH(NWIDTH), .MAXN(MAXN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NWIDTH-1:0] n;
        logic [WIDTH-1:0]  res;
        logic              err;
        int                lat;
    } vec_t;

    vec_t        vecs [9];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One GO pulse; edge 0 is the accepting edge, lat is the edge entering FIN.
    task automatic do_run(input logic [NWIDTH-1:0] n, input logic [WIDTH-1:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int  lat;
        int  busy_bad;
        lat      = -1;
        busy_bad = 0;
        bus.go = 1'b1;
        bus.n  = n;
        tick();
        bus.go = 1'b0;
        bus.n  = ~n;
        check($sformatf("n%0d busy_at_edge0", n), 32'(bus.busy), 32'd1);
        check($sformatf("n%0d err_clear_at_go", n), 32'(bus.err), 32'd0);
        check($sformatf("n%0d result_hold", n), bus.result, exp_prev);
        for (int k = 1; k <= BUDGET; k++) begin
            tick();
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            check($sformatf("n%0d done_timeout", n), 32'd0, 32'd1);
        end else begin
            check($sformatf("n%0d latency", n), 32'(lat), 32'(exp_lat));
            check($sformatf("n%0d result", n), bus.result, exp_res);
            check($sformatf("n%0d err", n), 32'(bus.err), 32'(exp_err));
            check($sformatf("n%0d busy_during_run", n), 32'(busy_bad), 32'd0);
            tick();
            check($sformatf("n%0d done_one_cycle", n), 32'(bus.done), 32'd0);
            check($sformatf("n%0d idle_after_fin", n), 32'(bus.busy), 32'd0);
            check($sformatf("n%0d result_stable", n), bus.result, exp_res);
        end
        exp_prev = exp_res;
    endtask

    initial begin
        int          dones;
        int          done_edge [$];
        logic [31:0] res_at_done [$];

        vecs[0] = '{n: 4'd5,  res: 32'd120,       err: 1'b0, lat: 6};
        vecs[1] = '{n: 4'd0,  res: 32'd1,         err: 1'b0, lat: 2};
        vecs[2] = '{n: 4'd1,  res: 32'd1,         err: 1'b0, lat: 2};
        vecs[3] = '{n: 4'd12, res: 32'h1C8CFC00,  err: 1'b0, lat: 13};
        vecs[4] = '{n: 4'd13, res: 32'd0,         err: 1'b1, lat: 1};
        vecs[5] = '{n: 4'd15, res: 32'd0,         err: 1'b1, lat: 1};
        vecs[6] = '{n: 4'd3,  res: 32'd6,         err: 1'b0, lat: 4};
        vecs[7] = '{n: 4'd2,  res: 32'd2,         err: 1'b0, lat: 3};
        vecs[8] = '{n: 4'd7,  res: 32'h000013B0,  err: 1'b0, lat: 8};

        rst    = 1'b1;
        bus.go = 1'b1;
        bus.n  = 4'd5;
        tick();
        tick();
        check("reset busy",   32'(bus.busy), 32'd0);
        check("reset done",   32'(bus.done), 32'd0);
        check("reset err",    32'(bus.err),  32'd0);
        check("reset result", bus.result,    32'd0);
        rst    = 1'b0;
        bus.go = 1'b0;
        tick();
        exp_prev = 32'd0;

        for (int i = 0; i < 9; i++) begin
            do_run(vecs[i].n, vecs[i].res, vecs[i].err, vecs[i].lat);
            tick();
        end

        // N=4 with GO re-pulsed and N=9 driven across edges 2 and 3.
        dones = 0;
        done_edge.delete();
        bus.go = 1'b1;
        bus.n  = 4'd4;
        tick();
        bus.go = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 2) begin
                bus.go = 1'b1;
                bus.n  = 4'd9;
            end
            if (k == 4) bus.go = 1'b0;
            tick();
            if (bus.done === 1'b1) begin
                dones++;
                done_edge.push_back(k);
                check("repulse result", bus.result, 32'd24);
            end
        end
        check("repulse done_count", 32'(dones), 32'd1);
        if (done_edge.size() > 0) check("repulse latency", 32'(done_edge[0]), 32'd5);
        check("repulse idle", 32'(bus.busy), 32'd0);

        // GO held high with N=3: runs accepted at edges 0, 6, 12.
        done_edge.delete();
        res_at_done.delete();
        bus.go = 1'b1;
        bus.n  = 4'd3;
        for (int k = 0; k <= 17; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_edge.push_back(k);
                res_at_done.push_back(bus.result);
            end
        end
        bus.go = 1'b0;
        check("hold done_count", 32'(done_edge.size()), 32'd3);
        for (int j = 0; j < done_edge.size(); j++) begin
            check($sformatf("hold result%0d", j), res_at_done[j], 32'd6);
            check($sformatf("hold done_edge%0d", j), 32'(done_edge[j]), 32'(4 + 6 * j));
        end
        tick();
        check("hold idle", 32'(bus.busy), 32'd0);

        // RST asserted on edge 4 of an N=7 run.
        bus.go = 1'b1;
        bus.n  = 4'd7;
        tick();
        bus.go = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid busy",   32'(bus.busy), 32'd0);
        check("rstmid done",   32'(bus.done), 32'd0);
        check("rstmid err",    32'(bus.err),  32'd0);
        check("rstmid result", bus.result,    32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("rstmid no_done", 32'(dones), 32'd0);
        exp_prev = 32'd0;
        do_run(4'd7, 32'h000013B0, 1'b0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
